// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS sequencer: steps each instruction through fetch, decode, execute,
// memory and writeback, and arbitrates the shared memory port with an ack watchdog.
module multi_cycle_controller #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instruction_Code,
  input  logic             Alu_Zero,
  input  logic             Mem_Ack,
  output logic             Mem_Req,
  output logic             Mem_We,
  output logic             Mem_Addr_Sel,
  output logic             IR_Load,
  output logic             MDR_Load,
  output logic             PC_Write,
  output logic             PC_Src,
  output logic [5:0]       ALU_Op,
  output logic             ALU_Src,
  output logic             Reg_Dest,
  output logic             Reg_Wr,
  output logic             Mem_To_Reg,
  output logic             Instr_Done,
  output logic [CNT_W-1:0] Instr_Count,
  output logic             Error
);

  // state  | meaning
  // FETCH  | instruction read from memory at PC; PC <= PC+4 on ack
  // DECODE | opcode captured from IR; NOP retires here
  // EXEC   | ALU operation; branch resolves and retires here
  // MEM    | load/store access at ALU-result address
  // WB     | register file write
  // ERR    | illegal opcode or memory timeout; held until reset
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_IMM   = 6'b000001;
  localparam logic [5:0] OP_BR    = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [5:0]       opcode_q;
  logic [7:0]       tmo_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             error_q;
  logic [5:0]       dec_op;
  logic             in_mem_state, tmo_hit;

  logic       mem_req, mem_we, addr_sel, ir_load, mdr_load, pc_write, pc_src;
  logic [5:0] alu_op;
  logic       alu_src, reg_dest, reg_wr, mem_to_reg, done_raw;

  assign dec_op       = Instruction_Code[31:26];
  assign in_mem_state = (state_q == FETCH) || (state_q == MEM);
  assign tmo_hit      = in_mem_state && !Mem_Ack && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= FETCH;
      opcode_q    <= '0;
      tmo_cnt_q   <= '0;
      instr_cnt_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) opcode_q <= dec_op;
      // any state change clears the watchdog, so each request starts fresh
      if (state_d != state_q) tmo_cnt_q <= '0;
      else if (in_mem_state && !Mem_Ack) tmo_cnt_q <= tmo_cnt_q + 8'd1;
      if (done_raw) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      if (state_d == ERR) error_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    mdr_load   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_op     = '0;
    alu_src    = 1'b0;
    reg_dest   = 1'b0;
    reg_wr     = 1'b0;
    mem_to_reg = 1'b0;
    done_raw   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (Mem_Ack) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (tmo_hit) begin
          state_d = ERR;
        end
      end
      DECODE: begin
        if (Instruction_Code == 32'd0) begin
          done_raw = 1'b1;
          state_d  = FETCH;
        end else if (dec_op inside {OP_RTYPE, OP_IMM, OP_BR, OP_LW, OP_SW}) begin
          state_d = EXEC;
        end else begin
          state_d = ERR;
        end
      end
      EXEC: begin
        alu_op   = opcode_q;
        alu_src  = (opcode_q != OP_RTYPE);
        reg_dest = (opcode_q == OP_RTYPE);
        case (opcode_q)
          OP_BR: begin
            pc_src   = 1'b1;
            pc_write = Alu_Zero;
            done_raw = 1'b1;
            state_d  = FETCH;
          end
          OP_LW, OP_SW: state_d = MEM;
          default:      state_d = WB;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode_q == OP_SW);
        alu_op   = opcode_q;
        alu_src  = 1'b1;
        if (Mem_Ack) begin
          if (opcode_q == OP_SW) begin
            done_raw = 1'b1;
            state_d  = FETCH;
          end else begin
            mdr_load = 1'b1;
            state_d  = WB;
          end
        end else if (tmo_hit) begin
          state_d = ERR;
        end
      end
      WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = (opcode_q == OP_LW);
        reg_dest   = (opcode_q == OP_RTYPE);
        done_raw   = 1'b1;
        state_d    = FETCH;
      end
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // reset masks every output, including the registered count and error flag
  assign Mem_Req      = mem_req    & ~Reset;
  assign Mem_We       = mem_we     & ~Reset;
  assign Mem_Addr_Sel = addr_sel   & ~Reset;
  assign IR_Load      = ir_load    & ~Reset;
  assign MDR_Load     = mdr_load   & ~Reset;
  assign PC_Write     = pc_write   & ~Reset;
  assign PC_Src       = pc_src     & ~Reset;
  assign ALU_Op       = Reset ? 6'd0 : alu_op;
  assign ALU_Src      = alu_src    & ~Reset;
  assign Reg_Dest     = reg_dest   & ~Reset;
  assign Reg_Wr       = reg_wr     & ~Reset;
  assign Mem_To_Reg   = mem_to_reg & ~Reset;
  assign Instr_Done   = done_raw   & ~Reset;
  assign Instr_Count  = Reset ? '0 : instr_cnt_q;
  assign Error        = error_q    & ~Reset;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: per-instruction expectations derived from the
// latency and strobe rules (cycle totals and strobe tallies), plus directed corner cases.
module tb_multi_cycle_controller;
  localparam int ACK_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [31:0]      Instruction_Code = '0;
  logic             Alu_Zero = 1'b0;
  logic             Mem_Ack = 1'b0;
  logic             Mem_Req, Mem_We, Mem_Addr_Sel, IR_Load, MDR_Load, PC_Write, PC_Src;
  logic [5:0]       ALU_Op;
  logic             ALU_Src, Reg_Dest, Reg_Wr, Mem_To_Reg, Instr_Done, Error;
  logic [CNT_W-1:0] Instr_Count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 Clk = ~Clk;

  multi_cycle_controller #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Instruction_Code(Instruction_Code), .Alu_Zero(Alu_Zero),
    .Mem_Ack(Mem_Ack), .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr_Sel(Mem_Addr_Sel),
    .IR_Load(IR_Load), .MDR_Load(MDR_Load), .PC_Write(PC_Write), .PC_Src(PC_Src),
    .ALU_Op(ALU_Op), .ALU_Src(ALU_Src), .Reg_Dest(Reg_Dest), .Reg_Wr(Reg_Wr),
    .Mem_To_Reg(Mem_To_Reg), .Instr_Done(Instr_Done), .Instr_Count(Instr_Count),
    .Error(Error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({Mem_Req, Mem_We, Mem_Addr_Sel, IR_Load, MDR_Load, PC_Write, PC_Src, ALU_Op,
                ALU_Src, Reg_Dest, Reg_Wr, Mem_To_Reg, Instr_Done, Instr_Count, Error});
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    Mem_Ack = 1'b0;
    @(posedge Clk); #2;
    check("reset_outputs_zero", all_outs(), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    check("reset_fetch_req", 32'(Mem_Req), 32'd1);
    check("reset_count", 32'(Instr_Count), 32'd0);
    check("reset_error", 32'(Error), 32'd0);
    exp_count = 0;
  endtask

  // Runs one legal instruction; fw/mw are wait cycles before the fetch/data ack.
  task automatic run_instr(input string tag, input logic [31:0] code, input int fw,
                           input int mw, input logic z);
    logic [5:0] op;
    bit is_nop, is_ld, is_st, is_br, fin;
    int cyc, req, sel, we, ir, mdr, pcw, pcs, rw, dn, req_n;
    int exp_cyc;
    logic [5:0] exec_op;
    logic exec_src, wb_dest, wb_m2r;
    op = code[31:26];
    is_nop = (code == 32'd0);
    is_ld = (op == 6'b100011);
    is_st = (op == 6'b101011);
    is_br = (op == 6'b000010);
    {cyc, req, sel, we, ir, mdr, pcw, pcs, rw, dn, req_n} = '0;
    exec_op = '0; exec_src = 1'b0; wb_dest = 1'b0; wb_m2r = 1'b0; fin = 1'b0;
    Instruction_Code = code;
    Alu_Zero = z;
    while (!fin && cyc < 64) begin
      Mem_Ack = Mem_Req && (req_n == (Mem_Addr_Sel ? mw : fw));
      #1;
      if (cyc == fw + 2) begin
        exec_op = ALU_Op;
        exec_src = ALU_Src;
      end
      if (Reg_Wr) begin
        wb_dest = Reg_Dest;
        wb_m2r = Mem_To_Reg;
      end
      req += int'(Mem_Req);  sel += int'(Mem_Addr_Sel); we += int'(Mem_We);
      ir  += int'(IR_Load);  mdr += int'(MDR_Load);     pcw += int'(PC_Write);
      pcs += int'(PC_Src);   rw  += int'(Reg_Wr);       dn += int'(Instr_Done);
      if (Mem_Req) req_n = Mem_Ack ? 0 : req_n + 1;
      fin = Instr_Done;
      cyc++;
      @(posedge Clk); #1;
    end
    Mem_Ack = 1'b0;
    exp_cyc = fw + (is_nop ? 2 : is_br ? 3 : is_ld ? 5 + mw : is_st ? 4 + mw : 4);
    check($sformatf("%s_cycles", tag), cyc, exp_cyc);
    check($sformatf("%s_req", tag), req, fw + 1 + ((is_ld || is_st) ? mw + 1 : 0));
    check($sformatf("%s_addr_sel", tag), sel, (is_ld || is_st) ? mw + 1 : 0);
    check($sformatf("%s_we", tag), we, is_st ? mw + 1 : 0);
    check($sformatf("%s_ir_load", tag), ir, 1);
    check($sformatf("%s_mdr_load", tag), mdr, is_ld ? 1 : 0);
    check($sformatf("%s_pc_write", tag), pcw, (is_br && z) ? 2 : 1);
    check($sformatf("%s_pc_src", tag), pcs, is_br ? 1 : 0);
    check($sformatf("%s_reg_wr", tag), rw, (is_nop || is_br || is_st) ? 0 : 1);
    check($sformatf("%s_done", tag), dn, 1);
    if (!is_nop) begin
      check($sformatf("%s_alu_op", tag), 32'(exec_op), 32'(op));
      check($sformatf("%s_alu_src", tag), 32'(exec_src), (op != 6'd0) ? 32'd1 : 32'd0);
    end
    if (!(is_nop || is_br || is_st)) begin
      check($sformatf("%s_reg_dest", tag), 32'(wb_dest), (op == 6'd0) ? 32'd1 : 32'd0);
      check($sformatf("%s_mem_to_reg", tag), 32'(wb_m2r), is_ld ? 32'd1 : 32'd0);
    end
    exp_count = (exp_count + 1) % (1 << CNT_W);
    check($sformatf("%s_count", tag), 32'(Instr_Count), exp_count);
    check($sformatf("%s_no_error", tag), 32'(Error), 32'd0);
  endtask

  task automatic run_illegal();
    int bad;
    bad = 0;
    Instruction_Code = 32'hFC00_0000;
    Mem_Ack = 1'b1;
    @(posedge Clk); #1;
    Mem_Ack = 1'b0;
    #1;
    check("illegal_decode_no_error", 32'(Error), 32'd0);
    @(posedge Clk); #2;
    check("illegal_error_set", 32'(Error), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (Mem_Req !== 1'b0 || Error !== 1'b1) bad++;
      @(posedge Clk); #2;
    end
    check("illegal_hold_20", bad, 0);
  endtask

  task automatic run_fetch_timeout();
    int nreq;
    nreq = 0;
    Mem_Ack = 1'b0;
    Instruction_Code = 32'h0022_1820;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (Error) break;
      nreq += int'(Mem_Req);
      @(posedge Clk); #1;
    end
    check("timeout_req_cycles", nreq, ACK_TIMEOUT);
    check("timeout_error", 32'(Error), 32'd1);
    check("timeout_req_dropped", 32'(Mem_Req), 32'd0);
  endtask

  task automatic run_reset_in_mem();
    Instruction_Code = 32'h8C22_0004;
    Alu_Zero = 1'b0;
    Mem_Ack = 1'b1;
    @(posedge Clk); #1;
    Mem_Ack = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("rst_mem_in_mem", 32'({Mem_Req, Mem_Addr_Sel}), 32'd3);
    Reset = 1'b1;
    #1;
    check("rst_mem_outs_zero", all_outs(), 32'd0);
    @(posedge Clk); #1;
    check("rst_mem_outs_zero_next", all_outs(), 32'd0);
    Reset = 1'b0;
    #1;
    check("rst_mem_fetch_restart", 32'({Mem_Req, Mem_Addr_Sel}), 32'd2);
    check("rst_mem_count", 32'(Instr_Count), 32'd0);
    exp_count = 0;
  endtask

  initial begin
    logic [31:0] code;
    logic [25:0] low;
    int cls;

    do_reset();
    run_instr("rtype", 32'h0022_1820, 0, 0, 1'b0);
    run_instr("load_wait3", 32'h8C22_0004, 0, 3, 1'b0);

    do_reset();
    run_instr("store", 32'hAC22_0004, 0, 0, 1'b0);
    run_instr("branch_taken", 32'h0800_0010, 0, 0, 1'b1);
    run_instr("branch_not_taken", 32'h0800_0010, 0, 0, 1'b0);
    check("three_instr_count", 32'(Instr_Count), 32'd3);

    do_reset();
    run_instr("nop", 32'h0000_0000, 0, 0, 1'b0);
    run_illegal();
    do_reset();

    run_fetch_timeout();
    do_reset();
    run_instr("fetch_ack_4th", 32'h0022_1820, 3, 0, 1'b0);

    do_reset();
    run_reset_in_mem();

    do_reset();
    for (int i = 0; i < 40; i++) begin
      cls = int'($urandom_range(0, 5));
      low = 26'($urandom);
      case (cls)
        0:       code = 32'd0;
        1:       code = {6'b000000, low | 26'd1};
        2:       code = {6'b000001, low};
        3:       code = {6'b000010, low};
        4:       code = {6'b100011, low};
        default: code = {6'b101011, low};
      endcase
      run_instr($sformatf("rnd%0d", i), code, int'($urandom_range(0, ACK_TIMEOUT - 1)),
                int'($urandom_range(0, ACK_TIMEOUT - 1)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
